// File: rtl/bus_combiner_n.sv
// Parametrised multi-channel bus combiner (AND / OR / lowest-index priority).
// It also detects cycles where channels overlap and keeps per-frame collision statistics.
module bus_combiner_n #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic                    start_of_frame,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]       ch_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    collision_pulse,
  output logic                    frame_collision,
  output logic [CNT_W-1:0]        collision_count,
  output logic [CNT_W-1:0]        last_frame_count
);

  logic [WIDTH-1:0] ch_arr [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_arr[gi] = ch_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [WIDTH-1:0] and_acc, or_acc, pri_acc, comb_sel;
  logic             any_valid, multi_valid, overlap;

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             pulse_q, pulse_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] last_q, last_d;

  // Walk from the highest index down so the lowest valid channel lands in pri_acc last.
  always_comb begin
    and_acc     = '1;
    or_acc      = '0;
    pri_acc     = '0;
    any_valid   = 1'b0;
    multi_valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_valid[i]) begin
        and_acc = and_acc & ch_arr[i];
        or_acc  = or_acc | ch_arr[i];
        pri_acc = ch_arr[i];
        if (any_valid) multi_valid = 1'b1;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    comb_sel = and_acc;
    case (mode)
      2'b01:   comb_sel = or_acc;
      2'b10:   comb_sel = pri_acc;
      default: comb_sel = and_acc;
    endcase
  end

  assign overlap = enable & multi_valid;

  always_comb begin
    data_d  = (enable && any_valid) ? comb_sel : '0;
    valid_d = enable & any_valid;
    pulse_d = overlap;
    flag_d  = flag_q;
    count_d = count_q;
    last_d  = last_q;
    // An overlap coinciding with the frame strobe is credited to the new frame.
    if (start_of_frame) begin
      last_d  = count_q;
      flag_d  = overlap;
      count_d = overlap ? CNT_W'(1) : '0;
    end else if (overlap) begin
      flag_d = 1'b1;
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign out_data         = data_q;
  assign out_valid        = valid_q;
  assign collision_pulse  = pulse_q;
  assign frame_collision  = flag_q;
  assign collision_count  = count_q;
  assign last_frame_count = last_q;

endmodule

// File: tb/tb_bus_combiner_n.sv
// Self-checking bench for bus_combiner_n (WIDTH=8, NUM_CH=3, CNT_W=4): vector table,
// hand-written frame/saturation/reset sequences and random stimulus against a reference model.
module tb_bus_combiner_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        start_of_frame = 1'b0;
  logic [23:0] ch_data = '0;
  logic [2:0]  ch_valid = '0;
  logic [7:0]  out_data;
  logic        out_valid, collision_pulse, frame_collision;
  logic [3:0]  collision_count, last_frame_count;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_data, m_valid, m_pulse, m_flag, m_cnt, m_last;

  bus_combiner_n #(.WIDTH(8), .NUM_CH(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .start_of_frame(start_of_frame), .ch_data(ch_data), .ch_valid(ch_valid),
    .out_data(out_data), .out_valid(out_valid), .collision_pulse(collision_pulse),
    .frame_collision(frame_collision), .collision_count(collision_count),
    .last_frame_count(last_frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       en;
    logic [7:0] d2, d1, d0;
    logic [2:0] valid;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_pulse;
    int         exp_cnt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 0; m_valid = 0; m_pulse = 0; m_flag = 0; m_cnt = 0; m_last = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_data"}, int'(out_data), m_data);
    chk({tag, ".out_valid"}, int'(out_valid), m_valid);
    chk({tag, ".pulse"}, int'(collision_pulse), m_pulse);
    chk({tag, ".frame_coll"}, int'(frame_collision), m_flag);
    chk({tag, ".count"}, int'(collision_count), m_cnt);
    chk({tag, ".last"}, int'(last_frame_count), m_last);
  endtask

  // Drives one cycle of inputs, advances the model by the specification's rules, checks after the edge.
  task automatic step(input string tag, input logic [1:0] md, input logic en, input logic sof,
                      input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0,
                      input logic [2:0] vld);
    logic [7:0] ch [3];
    logic [7:0] res;
    int nv;
    bit ovl;
    mode = md; enable = en; start_of_frame = sof;
    ch_data = {d2, d1, d0}; ch_valid = vld;
    ch[0] = d0; ch[1] = d1; ch[2] = d2;
    nv = $countones(vld);
    res = 8'h00;
    if (en && nv > 0) begin
      if (md == 2'b01) begin
        res = 8'h00;
        for (int i = 0; i < 3; i++) if (vld[i]) res = res | ch[i];
      end else if (md == 2'b10) begin
        if (vld[0]) res = d0;
        else if (vld[1]) res = d1;
        else res = d2;
      end else begin
        res = 8'hFF;
        for (int i = 0; i < 3; i++) if (vld[i]) res = res & ch[i];
      end
    end
    ovl = en && (nv >= 2);
    @(posedge clk);
    #1;
    m_data = int'(res);
    m_valid = (en && nv > 0) ? 1 : 0;
    m_pulse = ovl ? 1 : 0;
    if (sof) begin
      m_last = m_cnt;
      m_cnt = ovl ? 1 : 0;
      m_flag = ovl ? 1 : 0;
    end else if (ovl) begin
      m_flag = 1;
      m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    end
    check_all(tag);
    mode = 2'b00; enable = 1'b0; start_of_frame = 1'b0; ch_data = '0; ch_valid = '0;
  endtask

  initial begin
    tbl[0] = '{2'd0, 1'b1, 8'hF0, 8'h3C, 8'hFF, 3'b111, 8'h30, 1'b1, 1'b1, 1};
    tbl[1] = '{2'd1, 1'b1, 8'hAA, 8'h3C, 8'hAA, 3'b010, 8'h3C, 1'b1, 1'b0, 1};
    tbl[2] = '{2'd1, 1'b1, 8'hAA, 8'h3C, 8'hAA, 3'b000, 8'h00, 1'b0, 1'b0, 1};
    tbl[3] = '{2'd2, 1'b1, 8'h22, 8'h11, 8'hAA, 3'b110, 8'h11, 1'b1, 1'b1, 2};
    tbl[4] = '{2'd2, 1'b0, 8'h22, 8'h11, 8'hAA, 3'b110, 8'h00, 1'b0, 1'b0, 2};
    tbl[5] = '{2'd3, 1'b1, 8'h0F, 8'h55, 8'hF3, 3'b101, 8'h03, 1'b1, 1'b1, 3};
    tbl[6] = '{2'd1, 1'b1, 8'h0F, 8'h55, 8'hF3, 3'b101, 8'hFF, 1'b1, 1'b1, 4};
    tbl[7] = '{2'd2, 1'b1, 8'h5A, 8'h00, 8'h00, 3'b100, 8'h5A, 1'b1, 1'b0, 4};
    tbl[8] = '{2'd0, 1'b1, 8'h00, 8'h00, 8'hC3, 3'b001, 8'hC3, 1'b1, 1'b0, 4};
    tbl[9] = '{2'd0, 1'b1, 8'h12, 8'h34, 8'h56, 3'b000, 8'h00, 1'b0, 1'b0, 4};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_held");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("after_reset");

    for (int k = 0; k < 10; k++) begin
      step($sformatf("vec%0d", k), tbl[k].mode, tbl[k].en, 1'b0,
           tbl[k].d2, tbl[k].d1, tbl[k].d0, tbl[k].valid);
      chk($sformatf("vec%0d.tbl_data", k), int'(out_data), int'(tbl[k].exp_data));
      chk($sformatf("vec%0d.tbl_valid", k), int'(out_valid), int'(tbl[k].exp_valid));
      chk($sformatf("vec%0d.tbl_pulse", k), int'(collision_pulse), int'(tbl[k].exp_pulse));
      chk($sformatf("vec%0d.tbl_count", k), int'(collision_count), tbl[k].exp_cnt);
      $display("vec%0d mode=%0d en=%0b valid=%03b -> data=%02h valid=%0b pulse=%0b count=%0d",
               k, tbl[k].mode, tbl[k].en, tbl[k].valid, out_data, out_valid,
               collision_pulse, collision_count);
    end

    // saturation: 20 cycles of two-channel overlap
    for (int k = 0; k < 20; k++)
      step("sat", 2'd0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h0F, 3'b011);
    chk("sat.count15", int'(collision_count), 15);
    chk("sat.flag", int'(frame_collision), 1);
    $display("saturation: count=%0d flag=%0b", collision_count, frame_collision);

    // frame boundary without overlap, after exactly 5 overlaps
    step("sof_a", 2'd0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000);
    for (int k = 0; k < 5; k++)
      step("cnt5", 2'd1, 1'b1, 1'b0, 8'h01, 8'h02, 8'h04, 3'b111);
    step("sof_b", 2'd0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 3'b001);
    chk("sof_b.last5", int'(last_frame_count), 5);
    chk("sof_b.count0", int'(collision_count), 0);
    chk("sof_b.flag0", int'(frame_collision), 0);
    $display("sof no overlap: last=%0d count=%0d flag=%0b", last_frame_count, collision_count, frame_collision);

    // frame boundary coinciding with overlap, after 7 overlaps
    for (int k = 0; k < 7; k++)
      step("cnt7", 2'd2, 1'b1, 1'b0, 8'h01, 8'h02, 8'h04, 3'b110);
    step("sof_c", 2'd0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 3'b011);
    chk("sof_c.last7", int'(last_frame_count), 7);
    chk("sof_c.count1", int'(collision_count), 1);
    chk("sof_c.flag1", int'(frame_collision), 1);
    $display("sof with overlap: last=%0d count=%0d flag=%0b", last_frame_count, collision_count, frame_collision);

    // back-to-back strobes, the second one with enable low
    step("sof_d", 2'd0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000);
    step("sof_e", 2'd0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 3'b111);
    chk("sof_e.last0", int'(last_frame_count), 0);
    $display("back-to-back sof: last=%0d count=%0d", last_frame_count, collision_count);

    // random stimulus against the model
    for (int k = 0; k < 400; k++) begin
      step("rnd", 2'($urandom_range(0, 3)), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 15) == 0), 8'($urandom), 8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)));
    end

    // asynchronous reset mid-frame with count=9
    step("sof_f", 2'd0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000);
    for (int k = 0; k < 9; k++)
      step("cnt9", 2'd1, 1'b1, 1'b0, 8'h81, 8'h42, 8'h24, 3'b101);
    chk("pre_rst.count9", int'(collision_count), 9);
    enable = 1'b1; ch_valid = 3'b111; ch_data = 24'hFFFFFF;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    $display("async reset: data=%02h count=%0d last=%0d flag=%0b", out_data, collision_count,
             last_frame_count, frame_collision);
    @(posedge clk);
    #1;
    check_all("rst_hold1");
    @(posedge clk);
    #1;
    check_all("rst_hold2");
    reset = 1'b0;
    enable = 1'b0; ch_valid = '0; ch_data = '0;
    step("post_rst", 2'd0, 1'b1, 1'b0, 8'h0F, 8'hF0, 8'hFF, 3'b011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_combiner_n.md
Name: bus_combiner_n

Overview:
- Parametrised successor to the 8-bit enable-gated bus AND.
- Combines NUM_CH WIDTH-bit channels, each with a valid (drawing-request) bit, into one registered output bus.
- Combining mode is selectable: AND, OR or lowest-index priority select.
- Also detects per-pixel overlap (two or more channels valid at once) and accumulates overlap statistics per frame for game collision logic.

Parameters:
- WIDTH, 8, bit width of each channel and of out_data.
- NUM_CH, 4, number of input channels; legal range 2..16.
- CNT_W, 8, width of the collision cycle counters.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global gate for combining and collision detection.
- mode  input  2  00=AND, 01=OR, 10=PRIORITY, 11=reserved (behaves as AND).
- start_of_frame  input  1  single-cycle frame boundary strobe.
- ch_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- ch_valid  input  NUM_CH  bit i qualifies channel i.
- out_data  output  WIDTH  registered combined bus.
- out_valid  output  1  registered; high when at least one channel contributed.
- collision_pulse  output  1  registered; high one cycle per overlapping input cycle.
- frame_collision  output  1  sticky overlap flag for the current frame.
- collision_count  output  CNT_W  overlap cycles counted in the current frame (saturating).
- last_frame_count  output  CNT_W  collision_count captured at the most recent start_of_frame.

Behaviour:
- Reset: all outputs and registers clear to 0 immediately on reset assertion, independent of clk. Reset asserted mid-frame discards all accumulated state.
- Latency: exactly 1 cycle from inputs to out_data, out_valid and collision_pulse. No combinational path from inputs to outputs.
- AND mode: out_data = AND of ch_data over the valid channels; invalid channels are treated as all-ones.
- OR mode: out_data = OR of ch_data over the valid channels; invalid channels are treated as zero.
- PRIORITY mode: out_data = ch_data of the lowest-index valid channel.
- No valid channels, any mode: out_data=0, out_valid=0.
- out_valid = OR of ch_valid.
- enable=0: next out_data=0, out_valid=0, collision_pulse=0. No collision is counted. frame_collision and both counters hold their values, and start_of_frame is still honoured.
- Overlap: enable=1 and popcount(ch_valid) >= 2. The next cycle then has collision_pulse=1, frame_collision=1, and collision_count increments. The counter saturates at 2^CNT_W-1 and does not wrap.
- start_of_frame:
  - last_frame_count <= collision_count.
  - collision_count <= 0 and frame_collision <= 0, unless overlap occurs in the same cycle.
  - If overlap is also present in that cycle, collision_count <= 1 and frame_collision <= 1; the overlap belongs to the new frame.
  - Back-to-back start_of_frame strobes are legal; each one captures and clears.
- Mode changes take effect on the next registered output. No state depends on mode.
- Mode 11 is bit-identical to mode 00.

Test Plan (WIDTH=8, NUM_CH=3, CNT_W=4):
1. Reset, then AND mode with enable=1. ch_data={0xF0,0x3C,0xFF} (ch2,ch1,ch0), ch_valid=3'b111 -> next cycle out_data=0x30, out_valid=1, collision_pulse=1, collision_count=1.
2. OR mode, ch_valid=3'b010, ch1=0x3C, other channels 0xAA -> out_data=0x3C, out_valid=1, collision_pulse=0. Then ch_valid=0 -> out_data=0x00, out_valid=0.
3. PRIORITY mode, ch_valid=3'b110, ch1=0x11, ch2=0x22 -> out_data=0x11, collision_pulse=1. Then enable=0 -> out_data=0, out_valid=0, and the counter holds.
4. Saturation: hold 2-channel overlap for 20 cycles -> collision_count climbs to 15 and stays at 15; frame_collision=1.
5. Frame boundary: count=5, then start_of_frame with no overlap -> last_frame_count=5, collision_count=0, frame_collision=0. Repeat with count=7 and overlap in the same cycle -> last_frame_count=7, collision_count=1, frame_collision=1.
6. Assert reset asynchronously mid-frame with count=9 -> all outputs are 0 before the next clk edge and remain 0 while reset is held.
